hazard_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage core.
- Sits alongside the forwarding unit and covers the hazards forwarding cannot resolve: load-use, control redirect, multi-cycle instruction/data memory, and halt drain.
- Drives per-stage register enables, bubble/flush controls, a halted flag and a stall performance counter.

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, redirect flushes, memory waits,
// halt drain and a saturating stall counter for the 5-stage core.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       id_Rs,
  input  logic [2:0]       id_Rt,
  input  logic             id_has_Rs,
  input  logic             id_has_Rt,
  input  logic             id_halt,
  input  logic [2:0]       ex_Rd,
  input  logic             ex_wr_en,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  assign load_use = ex_mem_read & ex_wr_en &
                    ((id_has_Rs & (id_Rs == ex_Rd)) | (id_has_Rt & (id_Rt == ex_Rd)));

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = (state_q == StHalted);

    unique case (state_q)
      StHalted: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end
      StDrain: begin
        // Front end frozen; only the back end keeps retiring, paced by data memory.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        id_ex_en     = ~dmem_stall;
        ex_mem_en    = ~dmem_stall;
        mem_wb_en    = ~dmem_stall;
        if (!dmem_stall) begin
          if (drain_q <= DW'(1)) state_d = StHalted;
          if (drain_q != '0) drain_d = drain_q - DW'(1);
        end
      end
      StRun, StMemWait: begin
        // MEM_WAIT falls straight back into RUN rules once memory completes.
        state_d = StRun;
        if (dmem_stall) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
          state_d   = StMemWait;
        end else if (ex_redirect) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (imem_stall) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end else if (id_halt) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          drain_d      = DW'(DRAIN_CYCLES);
          state_d      = StDrain;
        end
      end
      default: state_d = StRun;
    endcase

    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != StHalted) && !pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
